// File: rtl/dram_request_arbiter.sv
// Fixed-priority arbiter serialising SPI / bus-read / bus-write DRAM requests onto one controller command channel.
// Optional grant statistics counters are compiled in when ARB_STATS_EN is defined.
module dram_request_arbiter #(
  parameter int STARVE_LIMIT   = 8,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int TO_W           = 10
) (
  input  logic        clock,
  input  logic        reset_L,
  input  logic        load_address_spi,
  input  logic        load_address_busread,
  input  logic        load_address_buswrite,
  input  logic        dram_read_enbl_spi,
  input  logic        dram_read_enbl_busread,
  input  logic        dram_write_enbl_spi,
  input  logic        dram_write_enbl_buswrite,
  input  logic [15:0] dram_writedata_spi,
  input  logic [15:0] dram_writedata_buswrite,
  output logic        ctl_cmd_valid,
  input  logic        ctl_cmd_ready,
  output logic [1:0]  ctl_cmd_type,
  output logic [1:0]  ctl_addr_sel,
  output logic [15:0] ctl_writedata,
  input  logic        ctl_done,
  input  logic [15:0] ctl_readdata,
  output logic        done_spi,
  output logic        done_busread,
  output logic        done_buswrite,
  output logic [15:0] dram_readdata,
  output logic [2:0]  overrun_err,
  output logic        timeout_err,
  output logic [1:0]  dbg_state
`ifdef ARB_STATS_EN
  ,
  output logic [15:0] grant_cnt_spi,
  output logic [15:0] grant_cnt_busread,
  output logic [15:0] grant_cnt_buswrite
`endif
);

  // Command channel: a command transfers on a cycle where ctl_cmd_valid and
  // ctl_cmd_ready are both high; valid and the command fields stay stable until then.
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT_DONE = 2'd2} state_t;

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);
  localparam logic [SC_W-1:0] SC_ONE     = 1;
  localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_ONE     = 1;

  localparam int P_SPI_LD = 0;
  localparam int P_SPI_WR = 1;
  localparam int P_SPI_RD = 2;
  localparam int P_BR_LD  = 3;
  localparam int P_BR_RD  = 4;
  localparam int P_BW_LD  = 5;
  localparam int P_BW_WR  = 6;

  localparam logic [1:0] T_LD = 2'd0;
  localparam logic [1:0] T_RD = 2'd1;
  localparam logic [1:0] T_WR = 2'd2;
  localparam logic [1:0] SEL_SPI = 2'd0;
  localparam logic [1:0] SEL_BR  = 2'd1;
  localparam logic [1:0] SEL_BW  = 2'd2;

  state_t            state_q, state_d;
  logic [6:0]        pend_q, pend_d;
  logic [15:0]       wdata_spi_q, wdata_spi_d;
  logic [15:0]       wdata_bw_q, wdata_bw_d;
  logic [SC_W-1:0]   starve_q, starve_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic              valid_q, valid_d;
  logic [1:0]        type_q, type_d;
  logic [1:0]        sel_q, sel_d;
  logic [15:0]       cwdata_q, cwdata_d;
  logic [2:0]        done_q, done_d;
  logic [15:0]       rdata_q, rdata_d;
  logic [2:0]        ovr_q, ovr_d;
  logic              tmo_q, tmo_d;

  logic [6:0] strb;
  logic [6:0] clr;
  logic [6:0] ovr_hit;
  logic       grant;
  logic [1:0] win;
  logic       spi_pend, br_pend, bw_pend;

  assign strb = {dram_write_enbl_buswrite, load_address_buswrite,
                 dram_read_enbl_busread, load_address_busread,
                 dram_read_enbl_spi, dram_write_enbl_spi, load_address_spi};

  assign spi_pend = |pend_q[P_SPI_RD:P_SPI_LD];
  assign br_pend  = |pend_q[P_BR_RD:P_BR_LD];
  assign bw_pend  = |pend_q[P_BW_WR:P_BW_LD];

`ifdef ARB_STATS_EN
  logic [15:0] gcnt_spi_q, gcnt_spi_d;
  logic [15:0] gcnt_br_q, gcnt_br_d;
  logic [15:0] gcnt_bw_q, gcnt_bw_d;
`endif

  always_comb begin
    state_d  = state_q;
    clr      = '0;
    grant    = 1'b0;
    win      = SEL_SPI;
    valid_d  = valid_q;
    type_d   = type_q;
    sel_d    = sel_q;
    cwdata_d = cwdata_q;
    done_d   = '0;
    rdata_d  = rdata_q;
    tmo_d    = tmo_q;
    to_d     = to_q;
    starve_d = spi_pend ? starve_q : '0;

    case (state_q)
      IDLE: begin
        if (|pend_q) begin
          grant = 1'b1;
          if (spi_pend && (starve_q == STARVE_MAX || !(br_pend || bw_pend))) win = SEL_SPI;
          else if (bw_pend) win = SEL_BW;
          else win = SEL_BR;
          // Inside one requester: load, then write, then read.
          case (win)
            SEL_SPI: begin
              if (pend_q[P_SPI_LD]) begin
                type_d = T_LD;
                clr[P_SPI_LD] = 1'b1;
              end else if (pend_q[P_SPI_WR]) begin
                type_d = T_WR;
                cwdata_d = wdata_spi_q;
                clr[P_SPI_WR] = 1'b1;
              end else begin
                type_d = T_RD;
                clr[P_SPI_RD] = 1'b1;
              end
            end
            SEL_BR: begin
              if (pend_q[P_BR_LD]) begin
                type_d = T_LD;
                clr[P_BR_LD] = 1'b1;
              end else begin
                type_d = T_RD;
                clr[P_BR_RD] = 1'b1;
              end
            end
            default: begin
              if (pend_q[P_BW_LD]) begin
                type_d = T_LD;
                clr[P_BW_LD] = 1'b1;
              end else begin
                type_d = T_WR;
                cwdata_d = wdata_bw_q;
                clr[P_BW_WR] = 1'b1;
              end
            end
          endcase
          sel_d   = win;
          valid_d = 1'b1;
          state_d = ISSUE;
          if (win == SEL_SPI) starve_d = '0;
          else if (spi_pend && starve_q != STARVE_MAX) starve_d = starve_q + SC_ONE;
        end
      end
      ISSUE: begin
        if (ctl_cmd_ready) begin
          valid_d = 1'b0;
          to_d    = '0;
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (ctl_done) begin
          case (sel_q)
            SEL_SPI: done_d[0] = 1'b1;
            SEL_BR:  done_d[1] = 1'b1;
            default: done_d[2] = 1'b1;
          endcase
          if (type_q == T_RD) rdata_d = ctl_readdata;
          state_d = IDLE;
        end else if (to_q == TO_LAST) begin
          tmo_d   = 1'b1;
          state_d = IDLE;
        end else begin
          to_d = to_q + TO_ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A strobe landing on its own grant cycle is a fresh request, not an overrun.
    ovr_hit = strb & pend_q & ~clr;
    pend_d  = (pend_q & ~clr) | strb;
    ovr_d   = ovr_q | {|ovr_hit[P_BW_WR:P_BW_LD], |ovr_hit[P_BR_RD:P_BR_LD], |ovr_hit[P_SPI_RD:P_SPI_LD]};
    wdata_spi_d = (dram_write_enbl_spi && !ovr_hit[P_SPI_WR]) ? dram_writedata_spi : wdata_spi_q;
    wdata_bw_d  = (dram_write_enbl_buswrite && !ovr_hit[P_BW_WR]) ? dram_writedata_buswrite : wdata_bw_q;
  end

`ifdef ARB_STATS_EN
  always_comb begin
    gcnt_spi_d = gcnt_spi_q;
    gcnt_br_d  = gcnt_br_q;
    gcnt_bw_d  = gcnt_bw_q;
    if (grant && win == SEL_SPI && gcnt_spi_q != 16'hFFFF) gcnt_spi_d = gcnt_spi_q + 16'd1;
    if (grant && win == SEL_BR && gcnt_br_q != 16'hFFFF) gcnt_br_d = gcnt_br_q + 16'd1;
    if (grant && win == SEL_BW && gcnt_bw_q != 16'hFFFF) gcnt_bw_d = gcnt_bw_q + 16'd1;
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      gcnt_spi_q <= '0;
      gcnt_br_q  <= '0;
      gcnt_bw_q  <= '0;
    end else begin
      gcnt_spi_q <= gcnt_spi_d;
      gcnt_br_q  <= gcnt_br_d;
      gcnt_bw_q  <= gcnt_bw_d;
    end
  end

  assign grant_cnt_spi      = gcnt_spi_q;
  assign grant_cnt_busread  = gcnt_br_q;
  assign grant_cnt_buswrite = gcnt_bw_q;
`endif

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      wdata_spi_q <= '0;
      wdata_bw_q  <= '0;
      starve_q    <= '0;
      to_q        <= '0;
      valid_q     <= 1'b0;
      type_q      <= '0;
      sel_q       <= '0;
      cwdata_q    <= '0;
      done_q      <= '0;
      rdata_q     <= '0;
      ovr_q       <= '0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      wdata_spi_q <= wdata_spi_d;
      wdata_bw_q  <= wdata_bw_d;
      starve_q    <= starve_d;
      to_q        <= to_d;
      valid_q     <= valid_d;
      type_q      <= type_d;
      sel_q       <= sel_d;
      cwdata_q    <= cwdata_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      ovr_q       <= ovr_d;
      tmo_q       <= tmo_d;
    end
  end

  assign ctl_cmd_valid = valid_q;
  assign ctl_cmd_type  = type_q;
  assign ctl_addr_sel  = sel_q;
  assign ctl_writedata = cwdata_q;
  assign done_spi      = done_q[0];
  assign done_busread  = done_q[1];
  assign done_buswrite = done_q[2];
  assign dram_readdata = rdata_q;
  assign overrun_err   = ovr_q;
  assign timeout_err   = tmo_q;
  assign dbg_state     = state_q;

endmodule
